// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock valid/ready FIFO with an occupancy
// count, almost-full/almost-empty flags and a synchronous flush.
//
// Ports:
//   clk_i          rising-edge clock for all state
//   rstn_i         synchronous active-low reset (pointers and count to 0)
//   valid_i/data_i upstream word, accepted when valid_i & ready_o
//   ready_o        FIFO can accept a word this cycle
//   valid_o/data_o head word (first-word-fall-through), data_o is 0 when idle
//   ready_i        downstream takes the head word when valid_o & ready_i
//   flush_i        synchronous clear; blocks both handshakes while high
//   level_o        current occupancy (0..DEPTH)
//   almost_full_o  level_o >= AFULL_TH
//   almost_empty_o level_o <= AEMPTY_TH
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       valid_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          data_o,
    input  logic                       ready_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic push_s;
    logic pop_s;

    // Both handshakes are gated by reset and flush, so a flush cycle can
    // never move data; full/empty are decided by the count alone because
    // the pointers are equal in both cases.
    assign ready_o = (count_q != DEPTH_C) & rstn_i & ~flush_i;
    assign valid_o = (count_q != {CW{1'b0}}) & rstn_i & ~flush_i;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};

    assign push_s = valid_i & ready_o;
    assign pop_s  = valid_o & ready_i;

    assign level_o        = count_q;
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);

    // Next-state for pointers and occupancy; flush has priority over traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; the array itself is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: self-checking bench for fifo_param (default parameters).
// A queue-based reference model tracks the FIFO contents; directed table
// vectors cover reset/fill/drain, followed by streaming, backpressure,
// flush and randomized traffic phases.
module tb_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int AF     = DEPTH - 1;
    localparam int AE     = 1;
    localparam int LW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rstn;
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              ready_i;
    logic              flush;
    logic [LW-1:0]     level_o;
    logic              almost_full_o;
    logic              almost_empty_o;

    always #5 clk = ~clk;

    fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .valid_i       (valid_i),
        .data_i        (data_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .ready_i       (ready_i),
        .flush_i       (flush),
        .level_o       (level_o),
        .almost_full_o (almost_full_o),
        .almost_empty_o(almost_empty_o)
    );

    // Source must hold a rejected word; the FIFO must hold an unpopped head.
    assert property (@(posedge clk) disable iff (!rstn)
        (valid_i && !ready_o) |=> (valid_i && $stable(data_i)))
        else $error("upstream hold rule violated");
    assert property (@(posedge clk) disable iff (!rstn)
        (valid_o && !ready_i) |=> (flush || !rstn || (valid_o && $stable(data_o))))
        else $error("output hold rule violated");

    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] rx[$];
    int n_pass   = 0;
    int n_checks = 0;
    int max_level;
    bit last_push = 1'b0;

    typedef struct {
        logic rs, v;
        logic [7:0] d;
        logic r, f;
        logic e_rdy, e_vld;
        logic [7:0] e_dat;
        int   e_lvl;
        logic e_af, e_ae;
    } vec_t;

    vec_t tv[15];

    function automatic vec_t mk(input logic rs, v, input logic [7:0] d, input logic r, f,
                                input logic e_rdy, e_vld, input logic [7:0] e_dat,
                                input int e_lvl, input logic e_af, e_ae);
        vec_t t;
        t.rs = rs; t.v = v; t.d = d; t.r = r; t.f = f;
        t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_dat = e_dat;
        t.e_lvl = e_lvl; t.e_af = e_af; t.e_ae = e_ae;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic apply(input logic rs, v, input logic [7:0] d, input logic r, f);
        rstn = rs; valid_i = v; data_i = d; ready_i = r; flush = f;
    endtask

    // Compare all outputs against what the queue model implies right now.
    task automatic check_model(input string tag);
        bit er, ev;
        logic [7:0] ed;
        #1;
        er = rstn && !flush && (mq.size() < DEPTH);
        ev = rstn && !flush && (mq.size() > 0);
        ed = ev ? mq[0] : 8'h00;
        chk({tag, "_ready"}, ready_o, er);
        chk({tag, "_valid"}, valid_o, ev);
        chk({tag, "_data"},  data_o, ed);
        chk({tag, "_level"}, level_o, mq.size());
        chk({tag, "_afull"}, almost_full_o, mq.size() >= AF);
        chk({tag, "_aempty"}, almost_empty_o, mq.size() <= AE);
        if (int'(level_o) > max_level) max_level = level_o;
    endtask

    // One rising edge; the model applies the handshakes seen before the edge.
    task automatic tick;
        bit pu, po;
        logic [7:0] popped;
        pu = rstn && !flush && valid_i && (mq.size() < DEPTH);
        po = rstn && !flush && ready_i && (mq.size() > 0);
        popped = data_o;
        @(posedge clk);
        if (!rstn || flush) begin
            mq.delete();
            pu = 1'b0;
        end else begin
            if (po) begin
                chk("sink_data", popped, mq[0]);
                rx.push_back(popped);
                void'(mq.pop_front());
            end
            if (pu) mq.push_back(data_i);
        end
        last_push = pu;
        #1;
    endtask

    task automatic cyc(input logic rs, v, input logic [7:0] d, input logic r, f, input string tag);
        apply(rs, v, d, r, f);
        check_model(tag);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int nv;
        logic sv;
        logic [7:0] sd;

        //            rs v  d      r  f   rdy vld dat   lvl af ae
        tv[0]  = mk(0, 1, 8'hAA, 0, 0,  0, 0, 8'h00, 0, 0, 1);
        tv[1]  = mk(1, 1, 8'hAA, 0, 0,  1, 0, 8'h00, 0, 0, 1);
        tv[2]  = mk(1, 0, 8'h00, 1, 0,  1, 1, 8'hAA, 1, 0, 1);
        tv[3]  = mk(1, 1, 8'h01, 0, 0,  1, 0, 8'h00, 0, 0, 1);
        tv[4]  = mk(1, 1, 8'h02, 0, 0,  1, 1, 8'h01, 1, 0, 1);
        tv[5]  = mk(1, 1, 8'h03, 0, 0,  1, 1, 8'h01, 2, 0, 0);
        tv[6]  = mk(1, 1, 8'h04, 0, 0,  1, 1, 8'h01, 3, 1, 0);
        tv[7]  = mk(1, 1, 8'h05, 0, 0,  0, 1, 8'h01, 4, 1, 0);
        tv[8]  = mk(1, 1, 8'h05, 0, 0,  0, 1, 8'h01, 4, 1, 0);
        tv[9]  = mk(1, 1, 8'h05, 1, 0,  0, 1, 8'h01, 4, 1, 0);
        tv[10] = mk(1, 1, 8'h05, 1, 0,  1, 1, 8'h02, 3, 1, 0);
        tv[11] = mk(1, 0, 8'h00, 1, 0,  1, 1, 8'h03, 3, 1, 0);
        tv[12] = mk(1, 0, 8'h00, 1, 0,  1, 1, 8'h04, 2, 0, 0);
        tv[13] = mk(1, 0, 8'h00, 1, 0,  1, 1, 8'h05, 1, 0, 1);
        tv[14] = mk(1, 0, 8'h00, 1, 0,  1, 0, 8'h00, 0, 0, 1);

        // Reset, fill, hold-off at full, drain.
        apply(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 15; i++) begin
            apply(tv[i].rs, tv[i].v, tv[i].d, tv[i].r, tv[i].f);
            check_model($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_ready_c", i),  ready_o, tv[i].e_rdy);
            chk($sformatf("tbl%0d_valid_c", i),  valid_o, tv[i].e_vld);
            chk($sformatf("tbl%0d_data_c", i),   data_o, tv[i].e_dat);
            chk($sformatf("tbl%0d_level_c", i),  level_o, tv[i].e_lvl);
            chk($sformatf("tbl%0d_afull_c", i),  almost_full_o, tv[i].e_af);
            chk($sformatf("tbl%0d_aempty_c", i), almost_empty_o, tv[i].e_ae);
            tick();
        end

        // Continuous streaming of 256 words through the wrapping pointers.
        rx.delete();
        max_level = 0;
        nv = 1;
        for (int c = 0; c < 1000 && rx.size() < 256; c++) begin
            cyc(1'b1, nv <= 256, 8'(nv), 1'b1, 1'b0, "strm");
            if (last_push) nv++;
        end
        chk("strm_count", rx.size(), 256);
        for (int i = 0; i < rx.size(); i++)
            chk($sformatf("strm_order%0d", i), rx[i], (i + 1) & 8'hFF);
        chk("strm_maxlvl", max_level, 1);

        // Sink alternates ready on/off while the source never pauses.
        rx.delete();
        max_level = 0;
        nv = 1;
        for (int c = 0; c < 2000 && rx.size() < 256; c++) begin
            cyc(1'b1, nv <= 256, 8'(nv), c[0], 1'b0, "bp");
            if (last_push) nv++;
        end
        chk("bp_count", rx.size(), 256);
        for (int i = 0; i < rx.size(); i++)
            chk($sformatf("bp_order%0d", i), rx[i], (i + 1) & 8'hFF);
        chk("bp_maxlvl_le_depth", int'(max_level <= DEPTH), 1);
        chk("bp_reached_full", max_level, DEPTH);

        // Flush at level 3 with a word offered in the same cycle.
        cyc(1'b1, 1'b1, 8'h31, 1'b0, 1'b0, "fl");
        cyc(1'b1, 1'b1, 8'h32, 1'b0, 1'b0, "fl");
        cyc(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, "fl");
        apply(1'b1, 1'b1, 8'h34, 1'b0, 1'b1);
        check_model("fl_on");
        chk("fl_on_ready", ready_o, 0);
        chk("fl_on_valid", valid_o, 0);
        chk("fl_on_level", level_o, 3);
        tick();
        apply(1'b1, 1'b1, 8'h34, 1'b0, 1'b0);
        check_model("fl_after");
        chk("fl_after_level", level_o, 0);
        chk("fl_after_valid", valid_o, 0);
        chk("fl_after_ready", ready_o, 1);
        tick();
        apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check_model("fl_out");
        chk("fl_out_valid", valid_o, 1);
        chk("fl_out_data", data_o, 8'h34);
        chk("fl_out_level", level_o, 1);
        tick();
        apply(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_model("fl_end");
        chk("fl_end_level", level_o, 0);

        // Randomized traffic with occasional flush and reset.
        sv = 1'b0;
        sd = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            if (!sv || last_push) begin
                sv = ($urandom_range(0, 3) != 0);
                sd = 8'($urandom);
            end
            cyc($urandom_range(0, 59) != 0, sv, sd, $urandom_range(0, 2) != 0,
                $urandom_range(0, 24) == 0, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
